// File: rtl/mem_arb_defs.sv
// Shared definitions for the DRAM port arbiter: requester IDs, FSM states
// and the round-robin pick used when both requesters are pending.
package mem_arb_defs;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } req_id_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_e;

  // With both pending, the requester that did not win last time goes next.
  function automatic req_id_e rr_pick(input logic ic_pend, input logic dc_pend,
                                      input req_id_e last);
    if (ic_pend && dc_pend) begin
      return (last == REQ_DC) ? REQ_IC : REQ_DC;
    end
    return ic_pend ? REQ_IC : REQ_DC;
  endfunction

endpackage

// File: rtl/arb_req_latch.sv
// Holds one requester's strobe until the arbiter completes it; a new strobe is
// accepted in the completion cycle, otherwise a strobe while pending sets a sticky error.
module arb_req_latch
  import mem_arb_defs::*;
#(
  parameter int MEM_SCALE = 27,
  parameter int DWIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_oe,
  input  logic                 i_we,
  input  logic [MEM_SCALE-1:0] i_addr,
  input  logic [DWIDTH-1:0]    i_wdata,
  input  logic                 i_done,
  output logic                 o_pend,
  output logic                 o_we,
  output logic [MEM_SCALE-1:0] o_addr,
  output logic [DWIDTH-1:0]    o_wdata,
  output logic                 o_proto_err
);

  logic                 r_pend;
  logic                 r_we;
  logic [MEM_SCALE-1:0] r_addr;
  logic [DWIDTH-1:0]    r_wdata;
  logic                 r_proto_err;
  logic                 w_stb;
  logic                 w_accept;

  assign w_stb    = i_oe | i_we;
  assign w_accept = w_stb & (~r_pend | i_done);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend      <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pend <= 1'b1;
        r_we   <= i_we;
        r_addr <= i_addr;
        if (i_we) begin
          r_wdata <= i_wdata;
        end
      end else if (i_done) begin
        r_pend <= 1'b0;
      end
      if (w_stb && r_pend && !i_done) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign o_pend      = r_pend;
  assign o_we        = r_we;
  assign o_addr      = r_addr;
  assign o_wdata     = r_wdata;
  assign o_proto_err = r_proto_err;

endmodule

// File: rtl/dram_port_arbiter.sv
// Round-robin share of one DRAM word port between icache refill and dcache; one
// transaction in flight, strobe->mem strobe 2 cycles. ARB_STAT_EN adds grant/wait counters.
module dram_port_arbiter
  import mem_arb_defs::*;
#(
  parameter int MEM_SCALE = 27,
  parameter int DWIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ic_oe,
  input  logic [MEM_SCALE-1:0] ic_addr,
  output logic [DWIDTH-1:0]    ic_rdata,
  output logic                 ic_valid,
  input  logic                 dc_oe,
  input  logic                 dc_we,
  input  logic [MEM_SCALE-1:0] dc_addr,
  input  logic [DWIDTH-1:0]    dc_wdata,
  output logic [DWIDTH-1:0]    dc_rdata,
  output logic                 dc_valid,
  output logic                 mem_oe,
  output logic                 mem_we,
  output logic [MEM_SCALE-1:0] mem_addr,
  output logic [DWIDTH-1:0]    mem_wdata,
  input  logic [DWIDTH-1:0]    mem_rdata,
  input  logic                 mem_valid,
  output logic                 proto_err
`ifdef ARB_STAT_EN
  ,
  output logic [31:0]          arb_cnt_ic,
  output logic [31:0]          arb_cnt_dc,
  output logic [31:0]          arb_cnt_wait
`endif
);

  arb_state_e           r_state;
  arb_state_e           w_state_nxt;
  req_id_e              r_grant;
  req_id_e              r_rr_last;
  req_id_e              w_winner;
  logic                 r_mem_oe;
  logic                 r_mem_we;
  logic [MEM_SCALE-1:0] r_mem_addr;
  logic [DWIDTH-1:0]    r_mem_wdata;
  logic                 w_issue;
  logic                 w_ic_done;
  logic                 w_dc_done;

  logic                 w_ic_pend, w_dc_pend;
  logic                 w_ic_we, w_dc_we;
  logic [MEM_SCALE-1:0] w_ic_addr, w_dc_addr;
  logic [DWIDTH-1:0]    w_ic_wdata, w_dc_wdata;
  logic                 w_ic_err, w_dc_err;
  logic                 w_sel_we;
  logic [MEM_SCALE-1:0] w_sel_addr;
  logic [DWIDTH-1:0]    w_sel_wdata;

  arb_req_latch #(.MEM_SCALE(MEM_SCALE), .DWIDTH(DWIDTH)) u_ic_latch (
    .clk         (clk),
    .rst         (rst),
    .i_oe        (ic_oe),
    .i_we        (1'b0),
    .i_addr      (ic_addr),
    .i_wdata     ('0),
    .i_done      (w_ic_done),
    .o_pend      (w_ic_pend),
    .o_we        (w_ic_we),
    .o_addr      (w_ic_addr),
    .o_wdata     (w_ic_wdata),
    .o_proto_err (w_ic_err)
  );

  arb_req_latch #(.MEM_SCALE(MEM_SCALE), .DWIDTH(DWIDTH)) u_dc_latch (
    .clk         (clk),
    .rst         (rst),
    .i_oe        (dc_oe),
    .i_we        (dc_we),
    .i_addr      (dc_addr),
    .i_wdata     (dc_wdata),
    .i_done      (w_dc_done),
    .o_pend      (w_dc_pend),
    .o_we        (w_dc_we),
    .o_addr      (w_dc_addr),
    .o_wdata     (w_dc_wdata),
    .o_proto_err (w_dc_err)
  );

  assign w_winner    = rr_pick(w_ic_pend, w_dc_pend, r_rr_last);
  assign w_sel_we    = (w_winner == REQ_IC) ? w_ic_we    : w_dc_we;
  assign w_sel_addr  = (w_winner == REQ_IC) ? w_ic_addr  : w_dc_addr;
  assign w_sel_wdata = (w_winner == REQ_IC) ? w_ic_wdata : w_dc_wdata;

  // mem_valid outside WAIT is dropped: no completion is routed anywhere.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_ic_done   = 1'b0;
    w_dc_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ic_pend || w_dc_pend) begin
          w_issue     = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (mem_valid) begin
          w_ic_done   = (r_grant == REQ_IC);
          w_dc_done   = (r_grant == REQ_DC);
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_grant     <= REQ_IC;
      r_rr_last   <= REQ_DC;
      r_mem_oe    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_mem_oe <= w_issue & ~w_sel_we;
      r_mem_we <= w_issue & w_sel_we;
      if (w_issue) begin
        r_grant     <= w_winner;
        r_rr_last   <= w_winner;
        r_mem_addr  <= w_sel_addr;
        r_mem_wdata <= w_sel_wdata;
      end
    end
  end

  assign mem_oe    = r_mem_oe;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign ic_valid  = w_ic_done;
  assign dc_valid  = w_dc_done;
  assign ic_rdata  = mem_rdata;
  assign dc_rdata  = mem_rdata;
  assign proto_err = w_ic_err | w_dc_err;

`ifdef ARB_STAT_EN
  logic [31:0] r_cnt_ic;
  logic [31:0] r_cnt_dc;
  logic [31:0] r_cnt_wait;
  logic        w_ic_waiting;
  logic        w_dc_waiting;

  // A pending requester is waiting unless it is being issued or is in service.
  assign w_ic_waiting = w_ic_pend & ~(w_issue & (w_winner == REQ_IC))
                      & ~((r_state == WAIT) & (r_grant == REQ_IC));
  assign w_dc_waiting = w_dc_pend & ~(w_issue & (w_winner == REQ_DC))
                      & ~((r_state == WAIT) & (r_grant == REQ_DC));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_ic   <= '0;
      r_cnt_dc   <= '0;
      r_cnt_wait <= '0;
    end else begin
      if (w_issue && (w_winner == REQ_IC)) r_cnt_ic <= r_cnt_ic + 32'd1;
      if (w_issue && (w_winner == REQ_DC)) r_cnt_dc <= r_cnt_dc + 32'd1;
      if (w_ic_waiting || w_dc_waiting)    r_cnt_wait <= r_cnt_wait + 32'd1;
    end
  end

  assign arb_cnt_ic   = r_cnt_ic;
  assign arb_cnt_dc   = r_cnt_dc;
  assign arb_cnt_wait = r_cnt_wait;
`endif

endmodule
